// File: rtl/des_pkg.sv
// Shared DES tables, permutation helpers and sequencer types.
// Bit numbering is [N:1] with bit N holding DES bit 1.
package des_pkg;

  localparam int RC_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam int SHIFT_T [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2,
    1, 2, 2, 2, 2, 2, 2, 1
  };

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41, 9, 49, 17, 57, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,
    1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27,
    19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
    7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29,
    21, 13, 5, 28, 20, 12, 4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5,
    3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8,
    16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5,
    4, 5, 6, 7, 8, 9,
    8, 9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32, 1
  };

  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17,
    1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9,
    19, 13, 30, 6, 22, 11, 4, 25
  };

  // index = box*64 + row*16 + col
  localparam int SBOX_T [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11
  };

  function automatic logic [64:1] des_ip(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int i = 1; i <= 64; i++) y[65-i] = x[65-IP_T[i-1]];
    return y;
  endfunction

  function automatic logic [64:1] des_fp(input logic [64:1] x);
    logic [64:1] y;
    y = '0;
    for (int i = 1; i <= 64; i++) y[65-i] = x[65-FP_T[i-1]];
    return y;
  endfunction

  function automatic logic [56:1] des_pc1(input logic [64:1] x);
    logic [56:1] y;
    y = '0;
    for (int i = 1; i <= 56; i++) y[57-i] = x[65-PC1_T[i-1]];
    return y;
  endfunction

  function automatic logic [48:1] des_pc2(input logic [56:1] x);
    logic [48:1] y;
    y = '0;
    for (int i = 1; i <= 48; i++) y[49-i] = x[57-PC2_T[i-1]];
    return y;
  endfunction

  // Decrypt walks the encrypt schedule backwards, starting with no shift.
  function automatic logic [1:0] shift_amt(
    input logic dec,
    input logic [RC_W-1:0] idx
  );
    logic [RC_W-1:0] j;
    j = ~idx + 1'b1;
    if (!dec) return 2'(SHIFT_T[idx]);
    if (idx == '0) return 2'd0;
    return 2'(SHIFT_T[j]);
  endfunction

  function automatic logic [28:1] rot28(
    input logic [28:1] x,
    input logic [1:0] s,
    input logic right
  );
    logic [28:1] y;
    y = x;
    unique case (1'b1)
      (!right && s == 2'd1): y = {x[27:1], x[28]};
      (!right && s == 2'd2): y = {x[26:1], x[28:27]};
      (right && s == 2'd1): y = {x[1], x[28:2]};
      (right && s == 2'd2): y = {x[2:1], x[28:3]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_f.sv
// DES Feistel f-function: E expansion, key mix, S-boxes, P permutation.
// Purely combinational; shared by every round of the sequencer.
import des_pkg::*;

module des_f (
  input  logic [32:1] r,
  input  logic [48:1] k,
  output logic [32:1] f
);

  logic [48:1] w_e;
  logic [48:1] w_x;
  logic [32:1] w_s;
  logic [5:0]  w_b;

  always_comb begin
    w_e = '0;
    w_s = '0;
    w_b = '0;
    f   = '0;
    for (int i = 1; i <= 48; i++) w_e[49-i] = r[33-E_T[i-1]];
    w_x = w_e ^ k;
    // row = outer bits, column = inner four
    for (int j = 0; j < 8; j++) begin
      w_b = w_x[48-6*j -: 6];
      w_s[32-4*j -: 4] = 4'(SBOX_T[64*j
        + 16*int'({w_b[5], w_b[0]})
        + int'(w_b[4:1])]);
    end
    for (int i = 1; i <= 32; i++) f[33-i] = w_s[33-P_T[i-1]];
  end

endmodule

// File: rtl/des_iter_sequencer.sv
// Iterative DES controller: one Feistel round per clock, key schedule
// rotated in place, valid/ready on both request and response sides.
import des_pkg::*;

module des_iter_sequencer #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [64:1] in_block,
  input  logic [64:1] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [64:1] out_block,
  output logic        busy,
  output logic [3:0]  round_idx
);

  localparam logic [RC_W-1:0] LAST = RC_W'(ROUNDS - 1);

  state_t          r_state;
  logic [32:1]     r_l;
  logic [32:1]     r_r;
  logic [28:1]     r_c;
  logic [28:1]     r_d;
  logic            r_mode;
  logic [RC_W-1:0] r_round;
  logic [64:1]     r_out_block;
  logic            r_out_valid;

  logic [1:0]      w_sh;
  logic [28:1]     w_c;
  logic [28:1]     w_d;
  logic [48:1]     w_k;
  logic [32:1]     w_f;
  logic [32:1]     w_nr;

  assign w_sh = shift_amt(r_mode, r_round);
  assign w_c  = rot28(r_c, w_sh, r_mode);
  assign w_d  = rot28(r_d, w_sh, r_mode);
  assign w_k  = des_pc2({w_c, w_d});
  assign w_nr = r_l ^ w_f;

  des_f u_f (
    .r (r_r),
    .k (w_k),
    .f (w_f)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_l         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_mode      <= 1'b0;
      r_round     <= '0;
      r_out_block <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            {r_l, r_r} <= des_ip(in_block);
            {r_c, r_d} <= des_pc1(in_key);
            r_mode     <= in_mode;
            r_round    <= '0;
            r_state    <= ROUND;
          end
        end
        ROUND: begin
          r_c <= w_c;
          r_d <= w_d;
          r_l <= r_r;
          r_r <= w_nr;
          if (r_round == LAST) begin
            r_round     <= '0;
            r_state     <= DONE;
            r_out_block <= des_fp({w_nr, r_r});
            r_out_valid <= 1'b1;
          end else begin
            r_round <= r_round + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign round_idx = r_round;
  assign out_valid = r_out_valid;
  assign out_block = r_out_block;

endmodule
